// File: rtl/verify_input.sv
// verify_input: checks Simon Says button presses against the stored colour sequence for a round
//   clk, rst_n            clock, asynchronous active-low reset
//   segment[32][3]        colour code per step (0-3 valid, 4-7 never match)
//   player_input[4]       raw button levels, one bit per colour, asynchronous to clk
//   check_round[5]        last step index to check, latched on start_check
//   start_check           one-cycle pulse starting a check (ignored unless idle)
//   busy, step_idx        check in progress / step being awaited
//   input_ok, input_fail  one-cycle result pulses
//   VERIFY_INPUT_TIMEOUT_EN: when defined, WAIT_PRESS fails after TIMEOUT_CYCLES idle cycles
module verify_input #(
    parameter int TIMEOUT_CYCLES = 50_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0][2:0] segment,
    input  logic [3:0]      player_input,
    input  logic [4:0]      check_round,
    input  logic            start_check,
    output logic            busy,
    output logic [4:0]      step_idx,
    output logic            input_ok,
    output logic            input_fail
);
    localparam logic [2:0] IDLE         = 3'd0;
    localparam logic [2:0] WAIT_PRESS   = 3'd1;
    localparam logic [2:0] WAIT_RELEASE = 3'd2;
    localparam logic [2:0] PASS         = 3'd3;
    localparam logic [2:0] FAIL         = 3'd4;
    logic [2:0] state, state_nx;
    logic [3:0] sync1, btn, btn_prev;
    logic [4:0] last_idx;
    logic [2:0] code;
    logic       press, match, timeout;
    assign code  = segment[step_idx];
    // btn_prev is tracked in every state, so a button already held at start never counts as a press
    assign press = |btn && !(|btn_prev);
    // equality with a single shifted bit also rejects multi-button presses
    assign match = !code[2] && btn == (4'b0001 << code[1:0]);
`ifdef VERIFY_INPUT_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    // cnt sits at zero outside WAIT_PRESS, so it restarts on every entry
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= state == WAIT_PRESS ? cnt + CW'(1) : '0;
    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
`else
    assign timeout = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:         state_nx = start_check ? WAIT_PRESS : IDLE;
            WAIT_PRESS:   state_nx = press ? (!match ? FAIL : step_idx == last_idx ? PASS : WAIT_RELEASE)
                                           : timeout ? FAIL : WAIT_PRESS;
            WAIT_RELEASE: state_nx = btn == 4'b0 ? WAIT_PRESS : WAIT_RELEASE;
            default:      state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sync1    <= '0;
            btn      <= '0;
            btn_prev <= '0;
            step_idx <= '0;
            last_idx <= '0;
        end else begin
            sync1    <= player_input;
            btn      <= sync1;
            btn_prev <= btn;
            state    <= state_nx;
            if (state == IDLE && start_check) begin
                last_idx <= check_round;
                step_idx <= '0;
            end else if (state == WAIT_RELEASE && btn == 4'b0) begin
                step_idx <= step_idx + 5'd1;
            end
        end
    end
    assign busy       = state != IDLE;
    assign input_ok   = state == PASS;
    assign input_fail = state == FAIL;
endmodule

// File: tb/tb_verify_input.sv
// tb_verify_input: scoreboard bench for verify_input
module tb_verify_input;
`ifdef VERIFY_INPUT_TIMEOUT_EN
    localparam int TO = 20;
`else
    localparam int TO = 50_000_000;
`endif
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [31:0][2:0] seg = '0;
    logic [3:0]       player_input = '0;
    logic [4:0]       check_round = '0;
    logic             start_check = 1'b0;
    logic             busy, input_ok, input_fail;
    logic [4:0]       step_idx;
    int               n_cmp = 0;
    int               n_bad = 0;
    logic [6:0]       exp_q[$];
    logic [6:0]       obs_q[$];

    verify_input #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .segment(seg), .player_input(player_input),
        .check_round(check_round), .start_check(start_check), .busy(busy),
        .step_idx(step_idx), .input_ok(input_ok), .input_fail(input_fail)
    );

    always #5 clk = ~clk;

    // every result pulse is logged as {ok, fail, step_idx}
    always @(negedge clk)
        if (input_ok || input_fail) obs_q.push_back({input_ok, input_fail, step_idx});

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] r);
        check_round = r;
        start_check = 1'b1;
        cycles(1);
        start_check = 1'b0;
    endtask

    task automatic get_obs(output logic [6:0] o, output bit got);
        got = 1'b0;
        o = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            if (obs_q.size() > 0) begin
                o = obs_q.pop_front();
                got = 1'b1;
            end else cycles(1);
        end
    endtask

    task automatic test_reset;
        cycles(3);
        n_cmp++;
        if ({busy, input_ok, input_fail, step_idx} !== 8'b0) begin
            n_bad++;
            $display("FAIL reset_values: got busy/ok/fail/idx=%b expected 00000000", {busy, input_ok, input_fail, step_idx});
        end
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_full_round;
        logic [3:0] pats[5] = '{4'b0100, 4'b0001, 4'b1000, 4'b0010, 4'b0100};
        logic [6:0] o, e;
        bit got;
        seg = '0;
        seg[0] = 3'd2; seg[1] = 3'd0; seg[2] = 3'd3; seg[3] = 3'd1; seg[4] = 3'd2;
        do_start(5'd4);
        n_cmp++;
        if ({busy, step_idx} !== 6'b1_00000) begin
            n_bad++;
            $display("FAIL full_start: got busy/idx=%b expected 100000", {busy, step_idx});
        end
        for (int i = 0; i < 5; i++) begin
            player_input = pats[i];
            if (i == 4) begin
                exp_q.push_back({2'b10, 5'd4});
                cycles(2);
                n_cmp++;
                if (input_ok !== 1'b0) begin
                    n_bad++;
                    $display("FAIL full_early_ok: got %b expected 0", input_ok);
                end
                cycles(1);
                n_cmp++;
                if (input_ok !== 1'b1) begin
                    n_bad++;
                    $display("FAIL full_latency_ok: got %b expected 1", input_ok);
                end
            end else begin
                cycles(3);
                n_cmp++;
                if (step_idx !== 5'(i)) begin
                    n_bad++;
                    $display("FAIL full_held_idx%0d: got %0d expected %0d", i, step_idx, i);
                end
            end
            player_input = 4'b0;
            cycles(4);
            if (i < 4) begin
                n_cmp++;
                if ({busy, step_idx} !== {1'b1, 5'(i + 1)}) begin
                    n_bad++;
                    $display("FAIL full_step%0d: got busy/idx=%b expected %b", i, {busy, step_idx}, {1'b1, 5'(i + 1)});
                end
            end
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL full_busy_end: got %b expected 0", busy);
        end
        get_obs(o, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || o !== e) begin
            n_bad++;
            $display("FAIL full_result: got %b (seen=%0d) expected %b", o, got, e);
        end
        n_cmp++;
        if (obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL full_extra_pulse: got %0d extra expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_mismatch;
        logic [3:0] pats[3] = '{4'b0100, 4'b0001, 4'b0010};
        logic [6:0] o, e;
        bit got;
        do_start(5'd2);
        for (int i = 0; i < 3; i++) begin
            if (i == 2) exp_q.push_back({2'b01, 5'd2});
            player_input = pats[i];
            cycles(4);
            player_input = 4'b0;
            cycles(4);
        end
        get_obs(o, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || o !== e) begin
            n_bad++;
            $display("FAIL mismatch_result: got %b (seen=%0d) expected %b", o, got, e);
        end
        n_cmp++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mismatch_extra: got pulses=%0d busy=%b expected 0 0", obs_q.size(), busy);
        end
        obs_q.delete();
    endtask

    task automatic test_multibit;
        logic [6:0] o, e;
        bit got;
        seg[0] = 3'd3;
        do_start(5'd0);
        exp_q.push_back({2'b01, 5'd0});
        player_input = 4'b1011;
        cycles(2);
        n_cmp++;
        if (input_fail !== 1'b0) begin
            n_bad++;
            $display("FAIL multibit_early: got %b expected 0", input_fail);
        end
        cycles(1);
        n_cmp++;
        if (input_fail !== 1'b1 || input_ok !== 1'b0) begin
            n_bad++;
            $display("FAIL multibit_latency: got fail/ok=%b%b expected 10", input_fail, input_ok);
        end
        player_input = 4'b0;
        cycles(4);
        get_obs(o, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || o !== e) begin
            n_bad++;
            $display("FAIL multibit_result: got %b (seen=%0d) expected %b", o, got, e);
        end
        obs_q.delete();
    endtask

    task automatic test_invalid_code;
        logic [6:0] o, e;
        bit got;
        seg[0] = 3'd5;
        do_start(5'd0);
        exp_q.push_back({2'b01, 5'd0});
        player_input = 4'b0001;
        cycles(4);
        player_input = 4'b0;
        cycles(4);
        get_obs(o, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || o !== e) begin
            n_bad++;
            $display("FAIL invalid_result: got %b (seen=%0d) expected %b", o, got, e);
        end
        obs_q.delete();
    endtask

    task automatic test_held_start;
        logic [6:0] o, e;
        bit got;
        seg[0] = 3'd2;
        player_input = 4'b0100;
        cycles(4);
        do_start(5'd0);
        cycles(6);
        n_cmp++;
        if (obs_q.size() != 0 || busy !== 1'b1 || step_idx !== 5'd0) begin
            n_bad++;
            $display("FAIL held_no_eval: got pulses=%0d busy=%b idx=%0d expected 0 1 0", obs_q.size(), busy, step_idx);
        end
        player_input = 4'b0;
        cycles(4);
        exp_q.push_back({2'b10, 5'd0});
        player_input = 4'b0100;
        cycles(4);
        player_input = 4'b0;
        cycles(3);
        get_obs(o, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || o !== e) begin
            n_bad++;
            $display("FAIL held_result: got %b (seen=%0d) expected %b", o, got, e);
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid;
        seg[0] = 3'd2; seg[1] = 3'd0;
        do_start(5'd4);
        player_input = 4'b0100;
        cycles(4);
        player_input = 4'b0;
        cycles(4);
        n_cmp++;
        if ({busy, step_idx} !== 6'b1_00001) begin
            n_bad++;
            $display("FAIL midreset_pre: got busy/idx=%b expected 100001", {busy, step_idx});
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, step_idx, input_ok, input_fail} !== 8'b0) begin
            n_bad++;
            $display("FAIL midreset_async: got busy/idx/ok/fail=%b expected 00000000", {busy, step_idx, input_ok, input_fail});
        end
        cycles(2);
        rst_n = 1'b1;
        cycles(4);
        n_cmp++;
        if (obs_q.size() != 0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset_pulse: got pulses=%0d busy=%b expected 0 0", obs_q.size(), busy);
        end
        obs_q.delete();
    endtask

`ifdef VERIFY_INPUT_TIMEOUT_EN
    task automatic test_timeout;
        logic [6:0] o, e;
        bit got;
        do_start(5'd0);
        exp_q.push_back({2'b01, 5'd0});
        cycles(19);
        n_cmp++;
        if (input_fail !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_early: got %b expected 0", input_fail);
        end
        cycles(1);
        n_cmp++;
        if (input_fail !== 1'b1) begin
            n_bad++;
            $display("FAIL timeout_fire: got %b expected 1", input_fail);
        end
        get_obs(o, got);
        e = exp_q.pop_front();
        n_cmp++;
        if (!got || o !== e) begin
            n_bad++;
            $display("FAIL timeout_result: got %b (seen=%0d) expected %b", o, got, e);
        end
        cycles(2);
        obs_q.delete();
    endtask
`endif

    initial begin
        test_reset;
        test_full_round;
        test_mismatch;
        test_multibit;
        test_invalid_code;
        test_held_start;
        test_reset_mid;
`ifdef VERIFY_INPUT_TIMEOUT_EN
        test_timeout;
`endif
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
